// File: rtl/ballplayer_image_sequencer.sv
// ballplayer_image_sequencer: slideshow scheduler for the 240x160 LCD renderer.
// Picks the image ID, issues one draw request per image over req/ack/done,
// then holds the image for a dwell time. It steps on dwell expiry, on the
// next/prev buttons, or after an abandoned (timed-out) draw.
module ballplayer_image_sequencer #(
  parameter int NUM_IMAGES     = 5,
  parameter int ID_W           = 3,
  parameter int DWELL_CYCLES   = 25000000,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            btn_next,
  input  logic            btn_prev,
  input  logic            pause_toggle,
  output logic            frame_req,
  input  logic            frame_ack,
  input  logic            frame_done,
  output logic [ID_W-1:0] image_id,
  output logic            display_active,
  output logic            paused,
  output logic            draw_error
);

  // One counter is shared by the draw timeout and the dwell timer. It never
  // holds more than max(DWELL_CYCLES, TIMEOUT_CYCLES) - 1.
  localparam int CNT_MAX = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST      = ID_W'(NUM_IMAGES - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DRAW, S_DWELL, S_STEP} state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_BACK} step_t;

  state_t           r_state;
  step_t            r_step;      // pending step in REQ/DRAW, step to apply in STEP
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_image_id;
  logic             r_frame_req;
  logic             r_display_active;
  logic             r_paused;
  logic             r_draw_error;

  logic             w_btn_one;
  step_t            w_btn_step;
  step_t            w_pend_next;
  logic             w_pause_eff;
  logic [ID_W-1:0]  w_id_fwd;
  logic [ID_W-1:0]  w_id_back;
  logic [ID_W-1:0]  w_id_btn;
  logic [ID_W-1:0]  w_id_step;

  // NOTE: all decode below is continuous assigns with a value on every path,
  // so no storage can be inferred outside the clocked block.
  // A simultaneous next+prev cancels out and counts as no press.
  assign w_btn_one   = btn_next ^ btn_prev;
  assign w_btn_step  = btn_next ? STEP_FWD : STEP_BACK;
  // Pending step including a press in the current cycle (last press wins).
  assign w_pend_next = w_btn_one ? w_btn_step : r_step;
  // Pause as it will be after this edge, so a toggle on the expiry cycle holds.
  assign w_pause_eff = r_paused ^ pause_toggle;

  assign w_id_fwd  = (r_image_id == ID_LAST) ? '0 : r_image_id + ID_W'(1);
  assign w_id_back = (r_image_id == '0) ? ID_LAST : r_image_id - ID_W'(1);
  assign w_id_btn  = btn_next ? w_id_fwd : w_id_back;
  assign w_id_step = (r_step == STEP_FWD)  ? w_id_fwd  :
                     (r_step == STEP_BACK) ? w_id_back : r_image_id;

  // Sequencer FSM: state, counter, image ID and all registered outputs.
  // NOTE: non-blocking assignments throughout; where a branch assigns the same
  // register twice, the later assignment in that branch is the one that sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_step           <= STEP_NONE;
      r_cnt            <= '0;
      r_image_id       <= '0;
      r_frame_req      <= 1'b0;
      r_display_active <= 1'b0;
      r_paused         <= 1'b0;
      r_draw_error     <= 1'b0;
    end else begin
      r_paused <= w_pause_eff;
      case (r_state)
        S_IDLE: begin
          if (w_btn_one) r_image_id <= w_id_btn;
          if (enable) begin
            r_state          <= S_REQ;
            r_frame_req      <= 1'b1;
            r_display_active <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_btn_one) r_step <= w_btn_step;
          if (frame_ack) begin
            r_state     <= S_DRAW;
            r_frame_req <= 1'b0;
            r_cnt       <= '0;
          end else if (!enable) begin
            r_state          <= S_IDLE;
            r_step           <= STEP_NONE;
            r_frame_req      <= 1'b0;
            r_display_active <= 1'b0;
          end
        end
        S_DRAW: begin
          if (w_btn_one) r_step <= w_btn_step;
          if (frame_done) begin
            r_display_active <= 1'b0;
            r_cnt            <= '0;
            if (w_pend_next != STEP_NONE) r_state <= S_STEP;
            else if (!enable)             r_state <= S_IDLE;
            else                          r_state <= S_DWELL;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_draw_error     <= 1'b1;
            r_display_active <= 1'b0;
            r_cnt            <= '0;
            r_state          <= S_STEP;
            r_step           <= (w_pend_next == STEP_NONE) ? STEP_FWD : w_pend_next;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DWELL: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_step  <= STEP_NONE;
          end else if (w_btn_one) begin
            r_state <= S_STEP;
            r_step  <= w_btn_step;
          end else if (!w_pause_eff) begin
            if (r_cnt == DWELL_LAST) begin
              r_state <= S_STEP;
              r_step  <= STEP_FWD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_STEP: begin
          r_image_id <= w_id_step;
          r_step     <= STEP_NONE;
          r_cnt      <= '0;
          if (enable) begin
            r_state          <= S_REQ;
            r_frame_req      <= 1'b1;
            r_display_active <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign frame_req      = r_frame_req;
  assign image_id       = r_image_id;
  assign display_active = r_display_active;
  assign paused         = r_paused;
  assign draw_error     = r_draw_error;

endmodule

// File: tb/tb_ballplayer_image_sequencer.sv
// tb_ballplayer_image_sequencer: directed bench for the slideshow sequencer,
// run with a short dwell (10) and draw timeout (20). The renderer handshake
// (ack 2 cycles after req, done 5 cycles after ack) is driven inline.
module tb_ballplayer_image_sequencer;

  localparam int NUM_IMAGES = 5;
  localparam int ID_W       = 3;
  localparam int DWELL      = 10;
  localparam int TIMEOUT    = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic            btn_next = 1'b0;
  logic            btn_prev = 1'b0;
  logic            pause_toggle = 1'b0;
  logic            frame_req;
  logic            frame_ack = 1'b0;
  logic            frame_done = 1'b0;
  logic [ID_W-1:0] image_id;
  logic            display_active;
  logic            paused;
  logic            draw_error;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ballplayer_image_sequencer #(
    .NUM_IMAGES    (NUM_IMAGES),
    .ID_W          (ID_W),
    .DWELL_CYCLES  (DWELL),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .btn_next      (btn_next),
    .btn_prev      (btn_prev),
    .pause_toggle  (pause_toggle),
    .frame_req     (frame_req),
    .frame_ack     (frame_ack),
    .frame_done    (frame_done),
    .image_id      (image_id),
    .display_active(display_active),
    .paused        (paused),
    .draw_error    (draw_error)
  );

  // Advance one clock; inputs set and outputs read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Single-cycle pulse on any combination of the user inputs.
  task automatic pulse(input logic nxt, input logic prv, input logic tgl);
    btn_next     = nxt;
    btn_prev     = prv;
    pause_toggle = tgl;
    tick();
    btn_next     = 1'b0;
    btn_prev     = 1'b0;
    pause_toggle = 1'b0;
  endtask

  // Wait (bounded) for frame_req; check the cycle count and the request's ID.
  task automatic wait_req(input string tag, input int exp_gap, input int exp_id);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_req !== 1'b1 && n < 200);
    check({tag, " req gap"}, n, exp_gap);
    check({tag, " req id"}, image_id, exp_id);
    check({tag, " req active"}, display_active, 1);
  endtask

  // Renderer acknowledges 2 cycles after the request is seen.
  task automatic do_ack(input string tag);
    tick();
    tick();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check({tag, " req low after ack"}, frame_req, 0);
    check({tag, " active in draw"}, display_active, 1);
  endtask

  // Renderer signals done after pre more cycles plus the done cycle itself.
  task automatic do_done(input string tag, input int pre);
    repeat (pre) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check({tag, " active low after done"}, display_active, 0);
  endtask

  initial begin
    int  n;
    logic seen;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst frame_req", frame_req, 0);
    check("rst image_id", image_id, 0);
    check("rst display_active", display_active, 0);
    check("rst paused", paused, 0);
    check("rst draw_error", draw_error, 0);

    // Prev wrap in IDLE: 0 -> 4, no draw
    pulse(1'b0, 1'b1, 1'b0);
    check("idle prev wrap id", image_id, 4);
    check("idle prev no req", frame_req, 0);
    tick();
    check("idle prev still no req", frame_req, 0);
    enable = 1'b1;
    wait_req("wrap", 1, 4);
    do_ack("wrap");

    // Reset mid-DRAW with paused set beforehand
    pulse(1'b0, 1'b0, 1'b1);
    check("draw pause set", paused, 1);
    enable = 1'b0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    check("mid rst frame_req", frame_req, 0);
    check("mid rst image_id", image_id, 0);
    check("mid rst display_active", display_active, 0);
    check("mid rst paused", paused, 0);
    check("mid rst draw_error", draw_error, 0);

    // Auto-cycle 0,1,2,3,4,0: req 1 cycle after enable, then 11 after each done
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_req($sformatf("auto%0d", k), (k == 0) ? 1 : 11, k % NUM_IMAGES);
      do_ack($sformatf("auto%0d", k));
      do_done($sformatf("auto%0d", k), 4);
    end

    // Simultaneous next+prev in DWELL: ignored, dwell runs on
    tick();
    pulse(1'b1, 1'b1, 1'b0);
    check("both btn id unchanged", image_id, 0);
    check("both btn no req", frame_req, 0);
    wait_req("both btn", 9, 1);
    do_ack("img1");
    do_done("img1", 4);

    // Pending step: next, next, prev during DRAW of id 2 -> skip dwell, id 1
    wait_req("img2", 11, 2);
    do_ack("pend");
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("pend id stable in draw", image_id, 2);
    do_done("pend", 1);
    wait_req("pend", 1, 1);

    // Pause at dwell count 5, hold 100 cycles, resume -> request 5 cycles later
    do_ack("pause");
    do_done("pause", 4);
    repeat (5) tick();
    pulse(1'b0, 1'b0, 1'b1);
    check("pause on", paused, 1);
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (frame_req === 1'b1) seen = 1'b1;
    end
    check("paused no req", seen, 0);
    check("paused id held", image_id, 1);
    pulse(1'b0, 1'b0, 1'b1);
    check("pause off", paused, 0);
    wait_req("resume", 5, 2);

    // btn_next while paused steps immediately
    do_ack("img2b");
    do_done("img2b", 4);
    pulse(1'b0, 1'b0, 1'b1);
    check("pause on again", paused, 1);
    repeat (3) tick();
    pulse(1'b1, 1'b0, 1'b0);
    check("paused next before step", image_id, 2);
    wait_req("paused next", 1, 3);
    pulse(1'b0, 1'b0, 1'b1);
    check("pause off again", paused, 0);

    // Timeout: ack but no done -> draw_error 20 cycles after ack, id advances
    do_ack("tmo");
    n = 0;
    while (draw_error !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("timeout cycles after ack", n, TIMEOUT);
    check("timeout active low", display_active, 0);
    wait_req("after tmo", 1, 4);
    check("err sticky in req", draw_error, 1);
    do_ack("img4");
    do_done("img4", 4);
    check("err sticky after good frame", draw_error, 1);
    wait_req("wrap fwd", 11, 0);
    check("err sticky at next req", draw_error, 1);

    enable = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ballplayer_image_sequencer.md
Name: ballplayer_image_sequencer

Overview:
- Slideshow scheduler that decides which stored image the 240x160 LCD renderer draws, and when.
- Issues one frame-draw request per image over a req/ack/done handshake, then holds the image for a programmable dwell time.
- Advances on dwell expiry or on user next/prev pulses, and supports pause.
- Sits between the board inputs/LED logic and the LCD multi-image display datapath, in the 25 MHz LCD clock domain.

Parameters:
- NUM_IMAGES, 5, number of images; IDs 0..NUM_IMAGES-1.
- ID_W, 3, width of image_id; must satisfy 2^ID_W >= NUM_IMAGES.
- DWELL_CYCLES, 25000000, clock cycles an image is held after its draw completes (1 s at 25 MHz).
- TIMEOUT_CYCLES, 4000000, maximum cycles from frame_ack to frame_done before the draw is abandoned.

Ports:
- clk, input, 1, 25 MHz LCD-domain clock; only clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, level; high runs the slideshow.
- btn_next, input, 1, single-cycle pulse (already debounced); advance one image.
- btn_prev, input, 1, single-cycle pulse (already debounced); go back one image.
- pause_toggle, input, 1, single-cycle pulse; toggles the paused flag.
- frame_req, output, 1, draw request to the renderer.
- frame_ack, input, 1, renderer accepted the request (1-cycle pulse).
- frame_done, input, 1, renderer finished the frame (1-cycle pulse).
- image_id, output, ID_W, image to draw and display.
- display_active, output, 1, high while a draw is requested or in progress.
- paused, output, 1, current pause state.
- draw_error, output, 1, sticky; set on draw timeout.

Behaviour:
- Reset values: frame_req=0, image_id=0, display_active=0, paused=0, draw_error=0. State=IDLE, counters=0, pending step cleared.
- Reset takes effect on the same clock edge it is sampled, including mid-draw. frame_req drops the following cycle.
- States:
  - IDLE: wait for enable=1, then go to REQ.
  - REQ: frame_req=1, display_active=1. Hold until frame_ack=1, then go to DRAW. frame_req is low in the cycle after ack.
  - DRAW: display_active=1. Timeout counter runs.
    - frame_done=1 -> DWELL, counter cleared.
    - Counter reaches TIMEOUT_CYCLES-1 without done -> set draw_error, go to STEP.
  - DWELL: counter increments each cycle unless paused=1 (frozen, not cleared). At DWELL_CYCLES-1 -> STEP with step=+1.
  - STEP: one cycle. Apply step to image_id, then go to REQ if enable=1, else IDLE.
- Stepping and wrap-around: +1 from NUM_IMAGES-1 wraps to 0; -1 from 0 wraps to NUM_IMAGES-1.
- image_id changes only in STEP, so it is stable from REQ through DWELL.
- btn_next / btn_prev in DWELL: go to STEP immediately with +1 / -1. This works while paused.
- btn_next / btn_prev in REQ or DRAW: latched as a single pending step; the last press wins. When frame_done arrives, the sequencer skips DWELL and goes to STEP with the pending step.
- btn_next and btn_prev in the same cycle: both ignored.
- Buttons in IDLE: applied to image_id directly in the next cycle (wrap rules apply), with no draw.
- pause_toggle: flips paused in any state. A pause_toggle in the same cycle that the dwell counter would expire is applied first, so the image holds.
- enable=0 in REQ before ack: drop frame_req and go to IDLE.
- enable=0 in DRAW: finish the draw (done or timeout), then go to IDLE.
- enable=0 in DWELL: go to IDLE.
- frame_ack or frame_done outside the state that expects them: ignored.
- draw_error clears only on rst.

Test Plan:
- Auto-cycle (DWELL_CYCLES=10; renderer model acks 2 cycles after req and signals done 5 cycles after ack): enable=1 -> image_id sequence 0,1,2,3,4,0. Each frame_req rises exactly 1 cycle after dwell expiry; display_active spans req..done.
- Prev wrap: idle at id 0, pulse btn_prev -> id=4 the next cycle, no frame_req. Then enable=1 -> first request carries id 4.
- Pending step: btn_next pulsed twice then btn_prev once during DRAW of id 2 -> on done, no dwell, next request carries id 1.
- Pause: pause_toggle at dwell count 5 -> counter holds at 5 for 100 cycles, no request. Second toggle -> request after 5 more cycles. btn_next while paused -> immediate step.
- Timeout (TIMEOUT_CYCLES=20): renderer acks but never sends done -> draw_error=1 at ack+20 cycles, id advances, draw_error stays 1 through later good frames.
- Reset mid-DRAW (rst high 1 cycle) -> the following cycle shows all outputs at reset values. Simultaneous btn_next+btn_prev in DWELL -> id unchanged, dwell continues.
